fetch_stage: RTL and testbench

//  IF stage of the 5-stage pipe, directly upstream of D. Owns the PC, issues one-outstanding

---
 rtl/fetch_stage_pkg.sv | 22 ++
 rtl/fetch_predecode.sv | 34 +++
 rtl/fetch_stage.sv | 137 +++++++++++++
 tb/tb_fetch_stage.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: control-flow opcodes (also used by ctrl)
// and the fetch FSM state encoding.
package fetch_stage_pkg;

  localparam int OPCODE_WIDTH = 7;

  localparam logic [OPCODE_WIDTH-1:0] IJAL  = 7'b1101111;
  localparam logic [OPCODE_WIDTH-1:0] IB    = 7'b1100011;
  localparam logic [OPCODE_WIDTH-1:0] IJALR = 7'b1100111;

  typedef enum logic [1:0] {
    FS_BOOT = 2'd0,
    FS_REQ  = 2'd1,
    FS_WAIT = 2'd2,
    FS_DROP = 2'd3
  } fetch_state_e;

  function automatic logic [OPCODE_WIDTH-1:0] opcode_of(input logic [31:0] inst);
    return inst[OPCODE_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/fetch_predecode.sv
// Static next-PC predictor: JAL and conditional branches are taken,
// everything else (including JALR) falls through to pc+4.
module fetch_predecode
  import fetch_stage_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] pc,
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] pred_pc
);

  logic signed [20:0]     j_imm;
  logic signed [12:0]     b_imm;
  logic signed [XLEN-1:0] j_off;
  logic signed [XLEN-1:0] b_off;

  assign j_imm = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign b_imm = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign j_off = {{(XLEN-21){j_imm[20]}}, j_imm};
  assign b_off = {{(XLEN-13){b_imm[12]}}, b_imm};

  // Targets wrap modulo 2^XLEN; the adds are deliberately unsigned.
  always_comb begin
    pred_pc = pc + XLEN'(4);
    case (opcode_of(inst))
      IJAL:    pred_pc = pc + $unsigned(j_off);
      IB:      pred_pc = pc + $unsigned(b_off);
      IJALR:   pred_pc = pc + XLEN'(4);
      default: pred_pc = pc + XLEN'(4);
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, keeps at most one instruction-memory fetch in flight
// and presents {pc, inst, pred_pc} to D, with a one-entry hold buffer for stalls.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            F_stall_i,
  input  logic            F_bubble_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ready_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            D_valid_o,
  output logic [XLEN-1:0] D_pc_o,
  output logic [31:0]     D_inst_o,
  output logic [XLEN-1:0] D_pred_pc_o
);

  fetch_state_e    state_q;
  fetch_state_e    state_d;
  logic [XLEN-1:0] pc_p0;
  logic [XLEN-1:0] pc_d;

  logic            flush;
  logic            accept;
  logic            rsp_v_p0;
  logic            rsp_take_p0;
  logic            hold_wr;
  logic [XLEN-1:0] rsp_pred_p0;

  logic            hold_v_p1;
  logic [XLEN-1:0] hold_pc_p1;
  logic [31:0]     hold_inst_p1;
  logic [XLEN-1:0] hold_pred_p1;

  assign flush = redirect_valid_i | F_bubble_i;

  // No new fetch while the hold buffer is occupied: D plus hold is full capacity.
  assign imem_req_o  = (state_q == FS_REQ) & ~hold_v_p1;
  assign imem_addr_o = pc_p0;
  assign accept      = imem_req_o & imem_ready_i;

  // Responses only count in WAIT; stale rvalid in BOOT/REQ and anything in DROP is ignored.
  assign rsp_v_p0    = (state_q == FS_WAIT) & imem_rvalid_i;
  assign rsp_take_p0 = rsp_v_p0 & ~flush;
  assign hold_wr     = rsp_take_p0 & (F_stall_i | hold_v_p1);

  fetch_predecode #(
    .XLEN (XLEN)
  ) u_predecode (
    .pc      (pc_p0),
    .inst    (imem_rdata_i),
    .pred_pc (rsp_pred_p0)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_p0;
    case (state_q)
      FS_BOOT: state_d = FS_REQ;
      FS_REQ: begin
        if (accept) state_d = flush ? FS_DROP : FS_WAIT;
      end
      FS_WAIT: begin
        // A response landing in the flush cycle closes the fetch; nothing left to drop.
        if (imem_rvalid_i) begin
          state_d = FS_REQ;
          if (!flush) pc_d = rsp_pred_p0;
        end else if (flush) begin
          state_d = FS_DROP;
        end
      end
      FS_DROP: begin
        if (imem_rvalid_i) state_d = FS_REQ;
      end
      default: state_d = FS_BOOT;
    endcase
    if (redirect_valid_i) pc_d = redirect_pc_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= FS_BOOT;
      pc_p0   <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_p0   <= pc_d;
    end
  end

  // ---- p0 -> p1: response into hold buffer or D registers ----
  always_ff @(posedge clk_i) begin
    if (hold_wr) begin
      hold_pc_p1   <= pc_p0;
      hold_inst_p1 <= imem_rdata_i;
      hold_pred_p1 <= rsp_pred_p0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hold_v_p1   <= 1'b0;
      D_valid_o   <= 1'b0;
      D_pc_o      <= '0;
      D_inst_o    <= '0;
      D_pred_pc_o <= '0;
    end else if (flush) begin
      hold_v_p1 <= 1'b0;
      D_valid_o <= 1'b0;
    end else if (!F_stall_i) begin
      if (hold_v_p1) begin
        D_valid_o   <= 1'b1;
        D_pc_o      <= hold_pc_p1;
        D_inst_o    <= hold_inst_p1;
        D_pred_pc_o <= hold_pred_p1;
        hold_v_p1   <= rsp_take_p0;
      end else if (rsp_take_p0) begin
        D_valid_o   <= 1'b1;
        D_pc_o      <= pc_p0;
        D_inst_o    <= imem_rdata_i;
        D_pred_pc_o <= rsp_pred_p0;
      end else begin
        D_valid_o <= 1'b0;
      end
    end else if (rsp_take_p0) begin
      hold_v_p1 <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed + randomized bench for fetch_stage: a lazily-filled instruction memory
// with random latency feeds an in-order delivery queue model of what D must see.
module tb_fetch_stage;

  localparam int          XLEN     = 64;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic [63:0] pred;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        F_stall_i, F_bubble_i, redirect_valid_i;
  logic [63:0] redirect_pc_i;
  logic        imem_req_o;
  logic [63:0] imem_addr_o;
  logic        imem_ready_i, imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        D_valid_o;
  logic [63:0] D_pc_o;
  logic [31:0] D_inst_o;
  logic [63:0] D_pred_pc_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_stage #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .F_stall_i        (F_stall_i),
    .F_bubble_i       (F_bubble_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_req_o       (imem_req_o),
    .imem_addr_o      (imem_addr_o),
    .imem_ready_i     (imem_ready_i),
    .imem_rvalid_i    (imem_rvalid_i),
    .imem_rdata_i     (imem_rdata_i),
    .D_valid_o        (D_valid_o),
    .D_pc_o           (D_pc_o),
    .D_inst_o         (D_inst_o),
    .D_pred_pc_o      (D_pred_pc_o)
  );

  // Reference: instructions fetched but not yet consumed by D, oldest first.
  ent_t        q[$];
  bit          shown;
  bit          boot;
  logic [63:0] fpc;
  // Memory responder state.
  bit          busy;
  bit          m_live;
  int          cnt;
  logic [63:0] m_addr;
  int          lat_fix;
  bit          spur_en;
  logic [31:0] mem_w [logic [63:0]];
  logic [63:0] mem_p [logic [63:0]];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [12:0] mid);
    return {imm[12], imm[10:5], mid, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic void preload(input logic [63:0] a, input logic [31:0] w, input logic [63:0] p);
    mem_w[a] = w;
    mem_p[a] = p;
  endfunction

  // Expected target is recorded from the offset used to build the word.
  function automatic void gen_word(input logic [63:0] a);
    logic [31:0] r;
    int          off;
    int          k;
    if (mem_w.exists(a)) return;
    r = $urandom;
    k = $urandom_range(0, 9);
    if (k <= 2) begin
      off = (k == 0) ? int'($urandom_range(0, 1048575)) - 524288
                     : int'($urandom_range(0, 2047)) - 1024;
      off = off * 2;
      mem_w[a] = enc_j(off[20:0], r[11:7]);
      mem_p[a] = a + 64'(longint'(off));
    end else if (k <= 5) begin
      off = (int'($urandom_range(0, 4095)) - 2048) * 2;
      mem_w[a] = enc_b(off[12:0], r[24:12]);
      mem_p[a] = a + 64'(longint'(off));
    end else if (k == 6) begin
      mem_w[a] = {r[31:7], 7'h67};
      mem_p[a] = a + 64'd4;
    end else begin
      if (r[6:0] == 7'h6f || r[6:0] == 7'h63) r[6:0] = 7'h13;
      mem_w[a] = r;
      mem_p[a] = a + 64'd4;
    end
  endfunction

  task automatic model_reset();
    q.delete();
    shown  = 1'b0;
    boot   = 1'b1;
    busy   = 1'b0;
    m_live = 1'b0;
    fpc    = RESET_PC;
  endtask

  task automatic check_outputs();
    bit holding;
    bit req_exp;
    holding = (q.size() > (shown ? 1 : 0));
    req_exp = !boot && !busy && !holding;
    chk("d_valid", D_valid_o, shown);
    if (shown) begin
      chk("d_pc", D_pc_o, q[0].pc);
      chk("d_inst", D_inst_o, q[0].inst);
      chk("d_pred", D_pred_pc_o, q[0].pred);
    end
    chk("req", imem_req_o, req_exp);
    if (req_exp) chk("addr", imem_addr_o, fpc);
  endtask

  // One clock: check at the negedge, drive this cycle's inputs, advance the model.
  task automatic step(input bit stall, input bit bubble, input bit redir,
                      input logic [63:0] rpc, input bit rdy);
    bit          rv, live, acc, fl;
    logic [31:0] rd;
    logic [63:0] raddr;
    ent_t        e;
    check_outputs();
    rv    = 1'b0;
    live  = 1'b0;
    rd    = $urandom;
    raddr = m_addr;
    if (busy) begin
      cnt--;
      if (cnt <= 0) begin
        gen_word(m_addr);
        rv   = 1'b1;
        live = m_live;
        rd   = mem_w[m_addr];
        busy = 1'b0;
      end
    end else if (spur_en && $urandom_range(0, 7) == 0) begin
      rv = 1'b1;
    end
    acc = imem_req_o && rdy;
    F_stall_i        = stall;
    F_bubble_i       = bubble;
    redirect_valid_i = redir;
    redirect_pc_i    = rpc;
    imem_ready_i     = rdy;
    imem_rvalid_i    = rv;
    imem_rdata_i     = rd;
    fl = bubble | redir;
    if (fl) begin
      q.delete();
      shown  = 1'b0;
      m_live = 1'b0;
      if (redir) fpc = rpc;
    end else begin
      if (!stall && shown) void'(q.pop_front());
      if (rv && live) begin
        e.pc   = raddr;
        e.inst = rd;
        e.pred = mem_p[raddr];
        q.push_back(e);
        fpc = mem_p[raddr];
      end
      if (!stall) shown = (q.size() != 0);
    end
    if (acc) begin
      busy   = 1'b1;
      cnt    = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 3));
      m_addr = imem_addr_o;
      m_live = !fl;
    end
    @(negedge clk);
    boot = 1'b0;
  endtask

  initial begin
    bit reached;
    rst_n = 1'b0;
    F_stall_i = 1'b0; F_bubble_i = 1'b0; redirect_valid_i = 1'b0; redirect_pc_i = '0;
    imem_ready_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    model_reset();
    lat_fix = 1;
    spur_en = 1'b0;
    preload(64'h8000_0000, 32'h0010_0093, 64'h8000_0004);
    preload(64'h8000_0004, 32'h0100_006f, 64'h8000_0014);
    preload(64'h8000_0014, 32'h0000_0013, 64'h8000_0018);
    preload(64'h8000_0100, 32'h0000_0013, 64'h8000_0104);
    preload(64'h8000_0104, 32'h0000_80e7, 64'h8000_0108);
    preload(64'hFFFF_FFFF_FFFF_FFFC, enc_j(21'd8, 5'd1), 64'h4);
    preload(64'h4, enc_b(13'h1FF0, 13'h0), 64'hFFFF_FFFF_FFFF_FFF4);

    repeat (2) @(negedge clk);
    chk("rst_req", imem_req_o, 0);
    chk("rst_valid", D_valid_o, 0);
    chk("rst_dpc", D_pc_o, 0);
    chk("rst_dinst", D_inst_o, 0);
    chk("rst_dpred", D_pred_pc_o, 0);

    // Boot: one cycle without request, then fetch RESET_PC.
    rst_n = 1'b1;
    chk("boot_req", imem_req_o, 0);
    step(0, 0, 0, 0, 1);
    chk("first_req", imem_req_o, 1);
    chk("first_addr", imem_addr_o, 64'h8000_0000);

    // Sequential instruction, 1-cycle memory latency.
    step(0, 0, 0, 0, 1);
    chk("seq_wait_req", imem_req_o, 0);
    step(0, 0, 0, 0, 1);
    chk("seq_valid", D_valid_o, 1);
    chk("seq_pc", D_pc_o, 64'h8000_0000);
    chk("seq_pred", D_pred_pc_o, 64'h8000_0004);
    chk("seq_next_addr", imem_addr_o, 64'h8000_0004);

    // JAL +16.
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("jal_inst", D_inst_o, 64'h0100_006f);
    chk("jal_pred", D_pred_pc_o, 64'h8000_0014);
    chk("jal_next_addr", imem_addr_o, 64'h8000_0014);

    // Stall three cycles; the response lands in hold while D stays frozen.
    step(1, 0, 0, 0, 1);
    chk("stall0_dpc", D_pc_o, 64'h8000_0004);
    step(1, 0, 0, 0, 1);
    chk("stall1_req", imem_req_o, 0);
    chk("stall1_dpc", D_pc_o, 64'h8000_0004);
    step(1, 0, 0, 0, 1);
    chk("stall2_req", imem_req_o, 0);
    step(0, 0, 0, 0, 0);
    chk("unstall_valid", D_valid_o, 1);
    chk("unstall_pc", D_pc_o, 64'h8000_0014);
    step(0, 0, 0, 0, 0);
    chk("unstall_once", D_valid_o, 0);

    // Redirect while waiting; the late response must be discarded.
    lat_fix = 3;
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 64'h8000_0100, 1);
    chk("redir_valid", D_valid_o, 0);
    chk("redir_drop_req", imem_req_o, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("redir_addr", imem_addr_o, 64'h8000_0100);
    chk("redir_req", imem_req_o, 1);
    chk("redir_still_empty", D_valid_o, 0);

    // Redirect together with stall while the hold buffer is full.
    lat_fix = 1;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("r6_dpc", D_pc_o, 64'h8000_0100);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    chk("r6_hold_req", imem_req_o, 0);
    step(1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0);
    chk("r6_valid", D_valid_o, 0);
    chk("r6_req", imem_req_o, 1);
    chk("r6_addr", imem_addr_o, 64'hFFFF_FFFF_FFFF_FFFC);

    // Wrap-around targets in both directions.
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("wrap_jal_pred", D_pred_pc_o, 64'h4);
    chk("wrap_next_addr", imem_addr_o, 64'h4);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("wrap_b_pred", D_pred_pc_o, 64'hFFFF_FFFF_FFFF_FFF4);

    // Randomized traffic.
    lat_fix = 0;
    spur_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      bit          st, bb, rr;
      logic [63:0] tgt;
      st  = ($urandom_range(0, 9) < 3);
      bb  = ($urandom_range(0, 31) == 0);
      rr  = ($urandom_range(0, 24) == 0);
      tgt = ($urandom_range(0, 1) == 0) ? {$urandom, $urandom}
                                        : fpc + 64'($urandom_range(0, 255) * 4);
      tgt[1:0] = 2'b00;
      step(st, bb, rr, tgt, ($urandom_range(0, 9) < 6));
    end

    // Asynchronous reset in WAIT while D holds a valid instruction.
    spur_en = 1'b0;
    lat_fix = 3;
    reached = 1'b0;
    for (int i = 0; i < 60 && !reached; i++) begin
      if (shown && busy) reached = 1'b1;
      else if (shown && q.size() == 1 && !busy) step(1, 0, 0, 0, 1);
      else step(0, 0, 0, 0, 1);
    end
    chk("reach_wait_with_d", reached, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", D_valid_o, 0);
    chk("async_rst_dpc", D_pc_o, 0);
    chk("async_rst_dinst", D_inst_o, 0);
    chk("async_rst_dpred", D_pred_pc_o, 0);
    chk("async_rst_req", imem_req_o, 0);
    model_reset();
    F_stall_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 1);
    chk("rerst_req", imem_req_o, 1);
    chk("rerst_addr", imem_addr_o, RESET_PC);
    lat_fix = 1;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    check_outputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
